// File: rtl/inst_s_dec_pkg.sv
// inst_s_dec_pkg: shared S-type store opcode, funct3 codes and store-size encoding
package inst_s_dec_pkg;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;
  typedef enum logic [1:0] {
    MS_BYTE   = 2'd0,
    MS_HALF   = 2'd1,
    MS_WORD   = 2'd2,
    MS_DOUBLE = 2'd3
  } mem_size_e;
endpackage

// File: rtl/inst_s_dec_s_imm_gen.sv
// s_imm_gen: slices S-format fields and sign-extends the split store offset
module s_imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:7]     i_word,
  output logic [6:0]      o_imm_msb,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rs1,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_imm_lsb,
  output logic [XLEN-1:0] o_imm
);
  assign o_imm_msb = i_word[31:25];
  assign o_rs2     = i_word[24:20];
  assign o_rs1     = i_word[19:15];
  assign o_funct3  = i_word[14:12];
  assign o_imm_lsb = i_word[11:7];
  assign o_imm     = {{(XLEN-12){i_word[31]}}, i_word[31:25], i_word[11:7]};
endmodule

// File: rtl/inst_s_dec.sv
// inst_s_dec: registered RISC-V S-type store decoder; INST_S_DEC_RV64_EN makes SD legal (use XLEN=64)
module inst_s_dec
  import inst_s_dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [31:0]     instruction_word,
  output logic            out_valid,
  output logic [6:0]      imm_MSB,
  output logic [4:0]      rs2,
  output logic [4:0]      rs1,
  output logic [4:0]      imm_LSB,
  output logic [2:0]      funct3,
  output logic [XLEN-1:0] imm,
  output logic [1:0]      mem_size,
  output logic            is_store,
  output logic            illegal
);
  logic [6:0]      w_imm_msb;
  logic [4:0]      w_rs2;
  logic [4:0]      w_rs1;
  logic [2:0]      w_funct3;
  logic [4:0]      w_imm_lsb;
  logic [XLEN-1:0] w_imm;
  logic            w_legal_f3;
  logic            w_legal;
  logic            r_valid;
  logic [6:0]      r_imm_msb;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rs1;
  logic [4:0]      r_imm_lsb;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_imm;
  mem_size_e       r_mem_size;
  logic            r_is_store;
  logic            r_illegal;

  s_imm_gen #(.XLEN(XLEN)) u_s_imm_gen (
    .i_word    (instruction_word[31:7]),
    .o_imm_msb (w_imm_msb),
    .o_rs2     (w_rs2),
    .o_rs1     (w_rs1),
    .o_funct3  (w_funct3),
    .o_imm_lsb (w_imm_lsb),
    .o_imm     (w_imm)
  );

`ifdef INST_S_DEC_RV64_EN
  assign w_legal_f3 = w_funct3 inside {F3_SB, F3_SH, F3_SW, F3_SD};
`else
  assign w_legal_f3 = w_funct3 inside {F3_SB, F3_SH, F3_SW};
`endif
  assign w_legal = (instruction_word[6:0] == OPCODE_STORE) && w_legal_f3;

  // Status flags track in_valid every cycle; fields only load on a valid word and hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_is_store <= 1'b0;
      r_illegal  <= 1'b0;
      r_imm_msb  <= '0;
      r_rs2      <= '0;
      r_rs1      <= '0;
      r_imm_lsb  <= '0;
      r_funct3   <= '0;
      r_imm      <= '0;
      r_mem_size <= MS_BYTE;
    end else begin
      r_valid    <= in_valid;
      r_is_store <= in_valid & w_legal;
      r_illegal  <= in_valid & ~w_legal;
      if (in_valid) begin
        r_imm_msb  <= w_imm_msb;
        r_rs2      <= w_rs2;
        r_rs1      <= w_rs1;
        r_imm_lsb  <= w_imm_lsb;
        r_funct3   <= w_funct3;
        r_imm      <= w_imm;
        r_mem_size <= mem_size_e'(w_funct3[1:0]);
      end
    end
  end

  assign out_valid = r_valid;
  assign imm_MSB   = r_imm_msb;
  assign rs2       = r_rs2;
  assign rs1       = r_rs1;
  assign imm_LSB   = r_imm_lsb;
  assign funct3    = r_funct3;
  assign imm       = r_imm;
  assign mem_size  = r_mem_size;
  assign is_store  = r_is_store;
  assign illegal   = r_illegal;
endmodule

// File: tb/tb_inst_s_dec.sv
// tb_inst_s_dec: randomized and directed self-checking bench for inst_s_dec
module tb_inst_s_dec;
`ifdef INST_S_DEC_RV64_EN
  localparam int XLEN = 64;
  localparam int MAX_LEGAL_F3 = 3;
`else
  localparam int XLEN = 32;
  localparam int MAX_LEGAL_F3 = 2;
`endif
  localparam int VW = XLEN + 30;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [31:0]     instruction_word = '0;
  logic            out_valid;
  logic [6:0]      imm_MSB;
  logic [4:0]      rs2;
  logic [4:0]      rs1;
  logic [4:0]      imm_LSB;
  logic [2:0]      funct3;
  logic [XLEN-1:0] imm;
  logic [1:0]      mem_size;
  logic            is_store;
  logic            illegal;

  int checks = 0;
  int failures = 0;

  logic [VW-1:0] e_all;
  logic [VW-1:0] got;
  assign got = {out_valid, imm_MSB, rs2, rs1, imm_LSB, funct3, imm, mem_size, is_store, illegal};

  inst_s_dec #(.XLEN(XLEN)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .imm_MSB          (imm_MSB),
    .rs2              (rs2),
    .rs1              (rs1),
    .imm_LSB          (imm_LSB),
    .funct3           (funct3),
    .imm              (imm),
    .mem_size         (mem_size),
    .is_store         (is_store),
    .illegal          (illegal)
  );

  always #5 clk = ~clk;

  // Reference state: what the decoder outputs should show after the last edge
  logic            m_valid, m_store, m_ill;
  logic [6:0]      m_msb;
  logic [4:0]      m_rs2, m_rs1, m_lsb;
  logic [2:0]      m_f3;
  logic [XLEN-1:0] m_imm;
  logic [1:0]      m_size;

  task automatic model_reset();
    {m_valid, m_store, m_ill, m_msb, m_rs2, m_rs1, m_lsb, m_f3, m_imm, m_size} = '0;
    e_all = '0;
  endtask

  task automatic model_apply(input logic v, input logic [31:0] w);
    int off;
    longint lo;
    bit legal;
    legal = (w % 128 == 35) && (int'((w / 4096) % 8) <= MAX_LEGAL_F3);
    m_valid = v;
    m_store = v && legal;
    m_ill = v && !legal;
    if (v) begin
      m_msb = 7'((w / 33554432) % 128);
      m_rs2 = 5'((w / 1048576) % 32);
      m_rs1 = 5'((w / 32768) % 32);
      m_f3  = 3'((w / 4096) % 8);
      m_lsb = 5'((w / 128) % 32);
      off = int'(m_msb) * 32 + int'(m_lsb);
      if (off >= 2048) off = off - 4096;
      lo = off;
      m_imm = lo[XLEN-1:0];
      m_size = 2'(int'(m_f3) % 4);
    end
    e_all = {m_valid, m_msb, m_rs2, m_rs1, m_lsb, m_f3, m_imm, m_size, m_store, m_ill};
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    @(negedge clk);
    in_valid = v;
    instruction_word = w;
    @(posedge clk);
    #1;
    model_apply(v, w);
  endtask

  function automatic logic [31:0] s_word(input int msb, input int r2, input int r1,
                                         input int f3, input int lsb, input int op);
    return 32'(msb * 33554432 + r2 * 1048576 + r1 * 32768 + f3 * 4096 + lsb * 128 + op);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    instruction_word = s_word(7, 0, 13, 2, 29, 35);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if (got !== e_all) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=%h", got, e_all);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got !== e_all) begin
      failures++;
      $display("FAIL reset_release_idle got=%h exp=%h", got, e_all);
    end
  endtask

  task automatic test_directed();
    logic signed [XLEN-1:0] k;
    drive(1'b1, 32'b0000111_00000_01101_010_11101_0100011);
    checks++;
    if ({imm_MSB, rs2, rs1, imm_LSB, funct3, mem_size, is_store, illegal, out_valid} !==
        {7'd7, 5'd0, 5'd13, 5'd29, 3'd2, 2'd2, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL dir1_fields got=%h", got);
    end
    k = 253;
    checks++;
    if (imm !== k) begin
      failures++;
      $display("FAIL dir1_imm got=%h exp=%h", imm, k);
    end
    drive(1'b1, 32'b0100101_10101_01100_010_01111_0100011);
    k = 1199;
    checks++;
    if ({imm_MSB, rs2, rs1, imm_LSB, is_store, imm} !== {7'd37, 5'd21, 5'd12, 5'd15, 1'b1, k}) begin
      failures++;
      $display("FAIL dir2 got=%h", got);
    end
    drive(1'b1, 32'b1000100_01011_00111_010_00001_0100011);
    k = -1919;
    checks++;
    if ({imm_MSB, rs2, rs1, imm_LSB, is_store, imm} !== {7'd68, 5'd11, 5'd7, 5'd1, 1'b1, k}) begin
      failures++;
      $display("FAIL dir3_negimm got=%h imm=%h exp_imm=%h", got, imm, k);
    end
    checks++;
    if (got !== e_all) begin
      failures++;
      $display("FAIL dir3_model got=%h exp=%h", got, e_all);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    w = s_word(5, 3, 9, 2, 6, 51);
    drive(1'b1, w);
    checks++;
    if ({illegal, is_store, rs1, imm_LSB} !== {1'b1, 1'b0, 5'd9, 5'd6} || got !== e_all) begin
      failures++;
      $display("FAIL illegal_opcode got=%h exp=%h", got, e_all);
    end
    w = s_word(100, 31, 1, 4, 31, 35);
    drive(1'b1, w);
    checks++;
    if ({illegal, is_store, funct3, mem_size} !== {1'b1, 1'b0, 3'd4, 2'd0} || got !== e_all) begin
      failures++;
      $display("FAIL illegal_f3_100 got=%h exp=%h", got, e_all);
    end
    w = s_word(1, 2, 3, 7, 4, 35);
    drive(1'b1, w);
    checks++;
    if ({illegal, is_store, mem_size} !== {1'b1, 1'b0, 2'd3} || got !== e_all) begin
      failures++;
      $display("FAIL illegal_f3_111 got=%h exp=%h", got, e_all);
    end
    w = s_word(2, 4, 6, 3, 8, 35);
    drive(1'b1, w);
    checks++;
`ifdef INST_S_DEC_RV64_EN
    if ({illegal, is_store, mem_size} !== {1'b0, 1'b1, 2'd3} || got !== e_all) begin
`else
    if ({illegal, is_store, mem_size} !== {1'b1, 1'b0, 2'd3} || got !== e_all) begin
`endif
      failures++;
      $display("FAIL sd_f3_011 got=%h exp=%h", got, e_all);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    for (int i = 0; i < 3; i++) begin
      w = s_word(int'($urandom_range(0, 127)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                 i, int'($urandom_range(0, 31)), 35);
      drive(1'b1, w);
      checks++;
      if (got !== e_all || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_word%0d got=%h exp=%h", i, got, e_all);
      end
    end
    drive(1'b0, $urandom);
    checks++;
    if (got !== e_all || out_valid !== 1'b0 || funct3 !== 3'd2) begin
      failures++;
      $display("FAIL b2b_hold got=%h exp=%h", got, e_all);
    end
  endtask

  task automatic test_midstream_reset();
    drive(1'b1, s_word(9, 9, 9, 1, 9, 35));
    @(negedge clk);
    in_valid = 1'b1;
    instruction_word = s_word(99, 8, 7, 0, 6, 35);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (got !== e_all) begin
      failures++;
      $display("FAIL async_reset got=%h exp=%h", got, e_all);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (got !== e_all) begin
      failures++;
      $display("FAIL discard_inflight got=%h exp=%h", got, e_all);
    end
    drive(1'b1, s_word(64, 1, 2, 0, 3, 35));
    checks++;
    if (got !== e_all || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_after_reset got=%h exp=%h", got, e_all);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic v;
    for (int i = 0; i < 300; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[6:0] = 7'b0100011;
      v = ($urandom_range(0, 3) != 0);
      drive(v, w);
      checks++;
      if (got !== e_all) begin
        failures++;
        $display("FAIL random_%0d w=%h v=%0b got=%h exp=%h", i, w, v, got, e_all);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_illegal();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end
endmodule
